calc_serial_rx: RTL and testbench
=================================

CALC_SERIAL_RX -- requirements
Module: calc_serial_rx

Interface
REQ-001 Parameters: INBITS, 8, calculator operand/result width.
REQ-002 Parameters: SBITS, 4, serial data bus width per beat.
REQ-003 Derived constant FLEN = 8+3*INBITS, frame length in bits; BEATS = FLEN/SBITS; FLEN%SBITS != 0 SHALL be an elaboration error.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-005 Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous active-high reset.
- ClkTx  input  1  divided transmit clock from calculator, synchronous to Clk.
- DoutValid  input  1  frame-in-progress qualifier.
- DataOut  input  SBITS  serial data beat.
- RxA  output  INBITS  received operand A.
- RxB  output  INBITS  received operand B.
- RxSel  output  4  received operation select.
- RxFlags  output  4  received status flags.
- RxResult  output  INBITS  received result.
- FrameValid  output  1  one-Clk pulse, new frame on Rx* outputs.
- FrameErr  output  1  one-Clk pulse, malformed frame.
- RxBusy  output  1  high while a frame is being received.

Function
REQ-006 Beat sampling: rising edge of ClkTx detected in Clk domain (ClkTx registered once, edge = ClkTx & ~ClkTx_q); DataOut and DoutValid sampled on the Clk cycle the edge is detected.
REQ-007 Frame layout, MSB first: [FLEN-1 -: INBITS] A, then B, then Sel[3:0], then Flags[3:0], then Result [INBITS-1:0].
REQ-008 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-009 IDLE -> SHIFT on a sampled beat with DoutValid=1; that beat is beat 0 and is shifted in; beat counter = 1.
REQ-010 SHIFT: each sampled beat with DoutValid=1 shifts SBITS bits in at LSB, counter increments; counter reaching BEATS -> DONE.
REQ-011 DONE: one Clk; Rx* outputs load from shift register, FrameValid=1, -> IDLE; latency = 1 Clk after the last beat's sampling cycle.
REQ-012 DoutValid observed low (any Clk) while in SHIFT with counter < BEATS: FrameErr pulse next Clk, frame discarded, -> IDLE, Rx* unchanged.
REQ-013 Beats with DoutValid=1 arriving after a completed frame while DoutValid never dropped: ignored; FrameErr pulse on the DoutValid fall; new frame only after DoutValid low then high.
REQ-014 Rx* outputs SHALL hold last good frame until next FrameValid.
REQ-015 RxBusy = 1 in SHIFT and DONE, 0 in IDLE.
REQ-016 FrameValid and FrameErr never both high in the same cycle.

Reset
REQ-017 Reset high at a Clk edge: FSM -> IDLE, counter, shift register, ClkTx_q, all Rx* = 0, FrameValid = FrameErr = RxBusy = 0.
REQ-018 Reset mid-frame: partial frame dropped, no FrameErr; reception restarts only after DoutValid low then high.

Configuration
REQ-019 Macro CALC_RX_STATS_EN: defined -> extra outputs FrameCnt[15:0], ErrCnt[15:0], saturating at 16'hFFFF, increment on FrameValid/FrameErr, cleared by Reset; undefined -> ports and counters absent, other behaviour identical.

Structure
REQ-020 Package calc_rx_pkg: FSM state typedef, FLEN/BEATS functions of INBITS/SBITS, field offset constants.
REQ-021 One sub-module calc_rx_edge: registers ClkTx, emits single-Clk rising-edge strobe.

Verification
REQ-022 INBITS=8, SBITS=4, divider 3; send 32'h0404_0008 as beats 0,4,0,4,0,0,0,8 -> FrameValid once, RxA=4, RxB=4, RxSel=0, RxFlags=0, RxResult=8.
REQ-023 DoutValid dropped after beat 5 -> FrameErr pulse, no FrameValid, Rx* keep previous frame.
REQ-024 Reset pulsed during beat 4, then full frame 32'h0A03_2007 -> no FrameErr, FrameValid with A=10, B=3, Sel=2, Flags=0, Result=7.
REQ-025 DoutValid held for 10 beats -> FrameValid after beat 8, beats 9-10 ignored, FrameErr on DoutValid fall.
REQ-026 Two back-to-back frames separated by one low DoutValid ClkTx period -> two FrameValid pulses, outputs update each time; with CALC_RX_STATS_EN, FrameCnt=2, ErrCnt=0.

Source files
------------

// File: rtl/calc_rx_pkg.sv
// Shared types and frame geometry for the calculator serial frame receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rx_state_t;

    localparam int SEL_W   = 4;
    localparam int FLAGS_W = 4;

    // Frame = A, B, Sel, Flags, Result, MSB first.
    function automatic int calc_flen(input int inbits);
        return SEL_W + FLAGS_W + 3 * inbits;
    endfunction

    function automatic int calc_beats(input int inbits, input int sbits);
        return calc_flen(inbits) / sbits;
    endfunction

    // Bit offsets of the top bit of each field within the assembled frame.
    function automatic int off_a(input int inbits);
        return calc_flen(inbits) - 1;
    endfunction

    function automatic int off_b(input int inbits);
        return calc_flen(inbits) - 1 - inbits;
    endfunction

    function automatic int off_sel(input int inbits);
        return inbits + FLAGS_W + SEL_W - 1;
    endfunction

    function automatic int off_flags(input int inbits);
        return inbits + FLAGS_W - 1;
    endfunction

    function automatic int off_res(input int inbits);
        return inbits - 1;
    endfunction

endpackage

// File: rtl/calc_rx_edge.sv
// Rising-edge detector for the calculator's divided transmit clock.
// Latency: strobe is combinational from the current ClkTx level vs. its one-cycle-old copy.
// Backpressure: none; one strobe per ClkTx rising edge.
module calc_rx_edge (
    input  logic clk,
    input  logic reset,
    input  logic clktx,
    output logic stb
);

    logic clktx_q;

    // Keep last cycle's ClkTx level to spot the low-to-high transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            clktx_q <= 1'b0;
        end else begin
            clktx_q <= clktx;
        end
    end

    assign stb = clktx & ~clktx_q;

endmodule

// File: rtl/calc_serial_rx.sv
// Receives serial calculator frames (A, B, Sel, Flags, Result) beat by beat on ClkTx edges.
// Latency: FrameValid and Rx* update 1 Clk after the last beat's sampling cycle.
// Backpressure: none; DoutValid drop mid-frame aborts with FrameErr. Optional stats: CALC_RX_STATS_EN.
module calc_serial_rx
    import calc_rx_pkg::*;
#(
    parameter int INBITS = 8,
    parameter int SBITS  = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               ClkTx,
    input  logic               DoutValid,
    input  logic [SBITS-1:0]   DataOut,
    output logic [INBITS-1:0]  RxA,
    output logic [INBITS-1:0]  RxB,
    output logic [SEL_W-1:0]   RxSel,
    output logic [FLAGS_W-1:0] RxFlags,
    output logic [INBITS-1:0]  RxResult,
    output logic               FrameValid,
    output logic               FrameErr,
    output logic               RxBusy
`ifdef CALC_RX_STATS_EN
    ,
    output logic [15:0]        FrameCnt,
    output logic [15:0]        ErrCnt
`endif
);

    localparam int FLEN  = calc_flen(INBITS);
    localparam int BEATS = calc_beats(INBITS, SBITS);
    localparam int CW    = $clog2(BEATS + 1);

    generate
        if (FLEN % SBITS != 0) begin : g_bad_geometry
            $error("calc_serial_rx: frame length must be a whole number of beats");
        end
    endgenerate

    rx_state_t            state;
    logic [CW-1:0]        cnt;
    // Only the first BEATS-1 beats need storing; the last beat is merged on the fly.
    logic [FLEN-SBITS-1:0] shreg;
    logic [FLEN-1:0]      shift_next;
    logic                 beat_stb;
    // need_low: a fresh frame may only start after DoutValid has been seen low.
    logic                 need_low;
    // post_frame: need_low was armed by a completed frame (not by reset).
    logic                 post_frame;
    // overrun: extra valid beats arrived after a completed frame.
    logic                 overrun;

    calc_rx_edge u_edge (
        .clk   (Clk),
        .reset (Reset),
        .clktx (ClkTx),
        .stb   (beat_stb)
    );

    assign shift_next = {shreg, DataOut};

    // Frame reception FSM with registered status and field outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            RxA        <= '0;
            RxB        <= '0;
            RxSel      <= '0;
            RxFlags    <= '0;
            RxResult   <= '0;
            FrameValid <= 1'b0;
            FrameErr   <= 1'b0;
            RxBusy     <= 1'b0;
            need_low   <= 1'b1;
            post_frame <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            FrameValid <= 1'b0;
            FrameErr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (need_low) begin
                        if (!DoutValid) begin
                            need_low   <= 1'b0;
                            post_frame <= 1'b0;
                            overrun    <= 1'b0;
                            FrameErr   <= overrun;
                        end else if (beat_stb && post_frame) begin
                            overrun <= 1'b1;
                        end
                    end else if (beat_stb && DoutValid) begin
                        shreg  <= shift_next[FLEN-SBITS-1:0];
                        cnt    <= CW'(1);
                        state  <= SHIFT;
                        RxBusy <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!DoutValid) begin
                        FrameErr <= 1'b1;
                        cnt      <= '0;
                        state    <= IDLE;
                        RxBusy   <= 1'b0;
                    end else if (beat_stb) begin
                        shreg <= shift_next[FLEN-SBITS-1:0];
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(BEATS - 1)) begin
                            RxA        <= shift_next[off_a(INBITS)     -: INBITS];
                            RxB        <= shift_next[off_b(INBITS)     -: INBITS];
                            RxSel      <= shift_next[off_sel(INBITS)   -: SEL_W];
                            RxFlags    <= shift_next[off_flags(INBITS) -: FLAGS_W];
                            RxResult   <= shift_next[off_res(INBITS)   -: INBITS];
                            FrameValid <= 1'b1;
                            state      <= DONE;
                            need_low   <= 1'b1;
                            post_frame <= 1'b1;
                            overrun    <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    RxBusy <= 1'b0;
                    if (!DoutValid) begin
                        need_low   <= 1'b0;
                        post_frame <= 1'b0;
                    end else if (beat_stb) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    RxBusy <= 1'b0;
                end
            endcase
        end
    end

`ifdef CALC_RX_STATS_EN
    // Saturating good-frame and error counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FrameCnt <= '0;
            ErrCnt   <= '0;
        end else begin
            if (FrameValid && FrameCnt != 16'hFFFF) begin
                FrameCnt <= FrameCnt + 16'd1;
            end
            if (FrameErr && ErrCnt != 16'hFFFF) begin
                ErrCnt <= ErrCnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_calc_serial_rx.sv
// Self-checking bench for calc_serial_rx with a frame scoreboard.
// Latency: ClkTx divided by 3 from Clk; one beat per ClkTx period.
// Backpressure: none; DoutValid drops and reset pulses exercised directly.
module tb_calc_serial_rx;

    localparam int INBITS = 8;
    localparam int SBITS  = 4;

    logic              Clk;
    logic              Reset;
    logic              ClkTx;
    logic              DoutValid;
    logic [SBITS-1:0]  DataOut;
    logic [INBITS-1:0] RxA;
    logic [INBITS-1:0] RxB;
    logic [3:0]        RxSel;
    logic [3:0]        RxFlags;
    logic [INBITS-1:0] RxResult;
    logic              FrameValid;
    logic              FrameErr;
    logic              RxBusy;
`ifdef CALC_RX_STATS_EN
    logic [15:0]       FrameCnt;
    logic [15:0]       ErrCnt;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          fv_seen  = 0;
    int          err_seen = 0;
    logic [31:0] exp_q[$];

    calc_serial_rx #(.INBITS(INBITS), .SBITS(SBITS)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ClkTx      (ClkTx),
        .DoutValid  (DoutValid),
        .DataOut    (DataOut),
        .RxA        (RxA),
        .RxB        (RxB),
        .RxSel      (RxSel),
        .RxFlags    (RxFlags),
        .RxResult   (RxResult),
        .FrameValid (FrameValid),
        .FrameErr   (FrameErr),
        .RxBusy     (RxBusy)
`ifdef CALC_RX_STATS_EN
        ,
        .FrameCnt   (FrameCnt),
        .ErrCnt     (ErrCnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Scoreboard: every FrameValid pops one expected frame and compares all fields.
    always @(negedge Clk) begin
        logic [31:0] w;
        if (FrameValid && FrameErr) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_err_overlap: got FrameValid=1 FrameErr=1 required not both");
        end
        if (FrameErr) err_seen++;
        if (FrameValid) begin
            fv_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_frame: got FrameValid=1 required no frame pending");
            end else begin
                w = exp_q.pop_front();
                if ({RxA, RxB, RxSel, RxFlags, RxResult} !== {w[31:24], w[23:16], w[15:12], w[11:8], w[7:0]}) begin
                    n_fail++;
                    $display("FAIL frame_fields: got A=%0h B=%0h Sel=%0h Flags=%0h Res=%0h required A=%0h B=%0h Sel=%0h Flags=%0h Res=%0h",
                             RxA, RxB, RxSel, RxFlags, RxResult, w[31:24], w[23:16], w[15:12], w[11:8], w[7:0]);
                end
            end
        end
    end

    // One ClkTx period (3 Clk): high for one Clk, data held for the whole period.
    task automatic tx_beat(input logic [3:0] d, input logic v);
        DataOut   = d;
        DoutValid = v;
        ClkTx     = 1'b1;
        @(negedge Clk);
        ClkTx = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
    endtask

    task automatic send_beats(input logic [31:0] w, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            tx_beat(w[31 - 4*i -: 4], 1'b1);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; ClkTx = 1'b0; DoutValid = 1'b0; DataOut = '0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if ({RxA, RxB, RxSel, RxFlags, RxResult} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rx: got %08h required 00000000", {RxA, RxB, RxSel, RxFlags, RxResult});
        end
        n_checks++;
        if ({FrameValid, FrameErr, RxBusy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status: got %03b required 000", {FrameValid, FrameErr, RxBusy});
        end
`ifdef CALC_RX_STATS_EN
        n_checks++;
        if ({FrameCnt, ErrCnt} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_stats: got %08h required 00000000", {FrameCnt, ErrCnt});
        end
`endif
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_basic_frame;
        int fv0 = fv_seen;
        int er0 = err_seen;
        logic [31:0] w = 32'h0404_0008;
        exp_q.push_back(w);
        send_beats(w, 0, 7);
        n_checks++;
        if (RxBusy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mid_frame: got %0b required 1", RxBusy);
        end
        DataOut = w[3:0]; DoutValid = 1'b1; ClkTx = 1'b1;
        @(negedge Clk);
        ClkTx = 1'b0;
        n_checks++;
        if ({FrameValid, RxBusy} !== 2'b11) begin
            n_fail++;
            $display("FAIL latency_valid: got FrameValid,RxBusy=%02b required 11", {FrameValid, RxBusy});
        end
        @(negedge Clk);
        n_checks++;
        if ({FrameValid, RxBusy} !== 2'b00) begin
            n_fail++;
            $display("FAIL valid_pulse_width: got FrameValid,RxBusy=%02b required 00", {FrameValid, RxBusy});
        end
        @(negedge Clk);
        tx_beat(4'h0, 1'b0);
        n_checks++;
        if (fv_seen - fv0 != 1 || err_seen != er0) begin
            n_fail++;
            $display("FAIL basic_counts: got frames=%0d errs=%0d required 1 0", fv_seen - fv0, err_seen - er0);
        end
    endtask

    task automatic test_drop_err;
        int fv0 = fv_seen;
        int er0 = err_seen;
        send_beats(32'h1122_3344, 0, 5);
        tx_beat(4'h0, 1'b0);
        n_checks++;
        if (fv_seen != fv0 || err_seen - er0 != 1) begin
            n_fail++;
            $display("FAIL drop_counts: got frames=%0d errs=%0d required 0 1", fv_seen - fv0, err_seen - er0);
        end
        n_checks++;
        if ({RxA, RxB, RxSel, RxFlags, RxResult} !== 32'h0404_0008) begin
            n_fail++;
            $display("FAIL drop_hold: got %08h required 04040008", {RxA, RxB, RxSel, RxFlags, RxResult});
        end
        n_checks++;
        if (RxBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_busy: got %0b required 0", RxBusy);
        end
    endtask

    task automatic test_reset_mid_frame;
        int fv0 = fv_seen;
        int er0 = err_seen;
        logic [31:0] w = 32'h0A03_2007;
        send_beats(w, 0, 4);
        DataOut = w[15:12]; DoutValid = 1'b1; ClkTx = 1'b1; Reset = 1'b1;
        @(negedge Clk);
        ClkTx = 1'b0; Reset = 1'b0;
        @(negedge Clk);
        n_checks++;
        if ({RxBusy, RxA, RxResult} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got busy=%0b A=%0h Res=%0h required 0 0 0", RxBusy, RxA, RxResult);
        end
        @(negedge Clk);
        send_beats(w, 5, 3);
        tx_beat(4'h0, 1'b0);
        n_checks++;
        if (fv_seen != fv0 || err_seen != er0) begin
            n_fail++;
            $display("FAIL reset_mid_counts: got frames=%0d errs=%0d required 0 0", fv_seen - fv0, err_seen - er0);
        end
        exp_q.push_back(w);
        send_beats(w, 0, 8);
        tx_beat(4'h0, 1'b0);
        n_checks++;
        if (fv_seen - fv0 != 1 || err_seen != er0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got frames=%0d errs=%0d required 1 0", fv_seen - fv0, err_seen - er0);
        end
        n_checks++;
        if ({RxA, RxB, RxSel, RxFlags} !== 24'h0A_03_2_0) begin
            n_fail++;
            $display("FAIL reset_mid_fields: got %06h required 0a0320", {RxA, RxB, RxSel, RxFlags});
        end
    endtask

    task automatic test_overrun;
        int fv0 = fv_seen;
        int er0 = err_seen;
        logic [31:0] w = 32'h5A3C_91E2;
        exp_q.push_back(w);
        send_beats(w, 0, 8);
        tx_beat(4'hF, 1'b1);
        tx_beat(4'hF, 1'b1);
        n_checks++;
        if (fv_seen - fv0 != 1 || err_seen != er0 || RxBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_ignore: got frames=%0d errs=%0d busy=%0b required 1 0 0", fv_seen - fv0, err_seen - er0, RxBusy);
        end
        tx_beat(4'h0, 1'b0);
        n_checks++;
        if (err_seen - er0 != 1 || fv_seen - fv0 != 1) begin
            n_fail++;
            $display("FAIL overrun_err: got frames=%0d errs=%0d required 1 1", fv_seen - fv0, err_seen - er0);
        end
        n_checks++;
        if ({RxA, RxB, RxSel, RxFlags, RxResult} !== w) begin
            n_fail++;
            $display("FAIL overrun_hold: got %08h required %08h", {RxA, RxB, RxSel, RxFlags, RxResult}, w);
        end
    endtask

    task automatic test_back_to_back;
        int fv0;
        int er0;
        logic [31:0] w1 = 32'h1234_5678;
        logic [31:0] w2 = 32'h8765_4321;
        DoutValid = 1'b0; Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        fv0 = fv_seen;
        er0 = err_seen;
        exp_q.push_back(w1);
        send_beats(w1, 0, 8);
        tx_beat(4'h0, 1'b0);
        n_checks++;
        if ({RxA, RxB, RxSel, RxFlags, RxResult} !== w1) begin
            n_fail++;
            $display("FAIL b2b_first: got %08h required %08h", {RxA, RxB, RxSel, RxFlags, RxResult}, w1);
        end
        exp_q.push_back(w2);
        send_beats(w2, 0, 8);
        tx_beat(4'h0, 1'b0);
        n_checks++;
        if ({RxA, RxB, RxSel, RxFlags, RxResult} !== w2) begin
            n_fail++;
            $display("FAIL b2b_second: got %08h required %08h", {RxA, RxB, RxSel, RxFlags, RxResult}, w2);
        end
        n_checks++;
        if (fv_seen - fv0 != 2 || err_seen != er0) begin
            n_fail++;
            $display("FAIL b2b_counts: got frames=%0d errs=%0d required 2 0", fv_seen - fv0, err_seen - er0);
        end
`ifdef CALC_RX_STATS_EN
        n_checks++;
        if (FrameCnt !== 16'd2 || ErrCnt !== 16'd0) begin
            n_fail++;
            $display("FAIL b2b_stats: got FrameCnt=%0d ErrCnt=%0d required 2 0", FrameCnt, ErrCnt);
        end
`endif
    endtask

    initial begin
        Reset = 1'b1; ClkTx = 1'b0; DoutValid = 1'b0; DataOut = '0;
        @(negedge Clk);
        test_reset();
        test_basic_frame();
        test_drop_err();
        test_reset_mid_frame();
        test_overrun();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_frames: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
